seg_scan_595: RTL

//  Parametrised multi-digit 7-segment scanner driving a 74HC595-style serial segment latch plus direct digit selects.

---
 rtl/seg_scan_595_if.sv | 33 +++
 rtl/seg_scan_595.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_595_if.sv
// seg_scan_595_if
//   Bundles the display-value inputs and the board-pin outputs of the
//   7-segment scanner.
//   master : display-value side (drives disnum/dp_en/blank, observes pins)
//   slave  : the scanner itself
//   disnum     4*NUM_DIGITS  nibble k shown on digit k
//   dp_en      NUM_DIGITS    decimal point per digit
//   blank      NUM_DIGITS    force digit dark
//   SER/SCLK/RCLK            74HC595 serial data, shift clock, latch pulse
//   SEL        NUM_DIGITS    one-hot digit select
//   frame_done 1             pulse with the latch of the last digit
interface seg_scan_595_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] disnum;
  logic [NUM_DIGITS-1:0]   dp_en;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    SER;
  logic                    SCLK;
  logic                    RCLK;
  logic [NUM_DIGITS-1:0]   SEL;
  logic                    frame_done;

  modport master (
    output disnum, dp_en, blank,
    input  SER, SCLK, RCLK, SEL, frame_done
  );

  modport slave (
    input  disnum, dp_en, blank,
    output SER, SCLK, RCLK, SEL, frame_done
  );
endinterface

// File: rtl/seg_scan_595.sv
// seg_scan_595
//   Multi-digit 7-segment scanner: hex-decodes one digit at a time, shifts
//   the segment byte into a 74HC595, latches it and selects the digit.
//   clk  : system clock
//   rst  : asynchronous reset, active high
//   bus  : seg_scan_595_if.slave (display value in, segment/select pins out)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | one cycle after reset release
//   S_LOAD  | snapshot inputs (digit 0 only), encode current digit byte
//   S_SHIFT | 8 bits out, SCLK low CLK_DIV cycles then high CLK_DIV
//   S_LATCH | RCLK pulse, SEL moves to current digit, frame_done on last
//   S_HOLD  | dwell DWELL cycles, then advance digit index
module seg_scan_595 #(
  parameter int NUM_DIGITS      = 4,
  parameter int CLK_DIV         = 1,
  parameter int DWELL           = 16,
  parameter bit SEL_ACTIVE_LOW  = 1'b1,
  parameter bit SEG_ACTIVE_HIGH = 1'b1,
  parameter bit LSB_FIRST       = 1'b1
) (
  input logic           clk,
  input logic           rst,
  seg_scan_595_if.slave bus
);

  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TMAX = (CLK_DIV > DWELL) ? CLK_DIV : DWELL;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [IW-1:0]         LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0]         DIV_LD   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0]         DWELL_LD = TW'(DWELL - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF  = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH, S_HOLD} state_t;

  state_t                  state_q, state_n;
  logic [IW-1:0]           idx_q, idx_n;
  logic [TW-1:0]           tmr_q, tmr_n;
  logic [2:0]              bit_q, bit_n;
  logic [7:0]              byte_q, byte_n;
  logic [4*NUM_DIGITS-1:0] sh_num_q, sh_num_n;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_n;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_n;
  logic                    ser_q, ser_n;
  logic                    sclk_q, sclk_n;
  logic                    rclk_q, rclk_n;
  logic [NUM_DIGITS-1:0]   sel_q, sel_n;
  logic                    fdone_q, fdone_n;

  logic [4*NUM_DIGITS-1:0] num_src;
  logic [NUM_DIGITS-1:0]   dp_src;
  logic [NUM_DIGITS-1:0]   blank_src;
  logic [3:0]              nib;
  logic [7:0]              seg;
  logic [7:0]              enc_byte;
  logic [NUM_DIGITS-1:0]   sel_on;

  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 8'hFC;
      4'h1: hex_seg = 8'h60;
      4'h2: hex_seg = 8'hDA;
      4'h3: hex_seg = 8'hF2;
      4'h4: hex_seg = 8'h66;
      4'h5: hex_seg = 8'hB6;
      4'h6: hex_seg = 8'hBE;
      4'h7: hex_seg = 8'hE0;
      4'h8: hex_seg = 8'hFE;
      4'h9: hex_seg = 8'hF6;
      4'hA: hex_seg = 8'hEE;
      4'hB: hex_seg = 8'h3E;
      4'hC: hex_seg = 8'h9C;
      4'hD: hex_seg = 8'h7A;
      4'hE: hex_seg = 8'h9E;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction

  // The byte is stored pre-ordered so SHIFT always sends byte_q[0] first.
  // At digit 0 the live inputs are used directly, because the shadow regs
  // only capture them at the end of this same LOAD cycle.
  always_comb begin
    num_src   = (idx_q == '0) ? bus.disnum : sh_num_q;
    dp_src    = (idx_q == '0) ? bus.dp_en  : sh_dp_q;
    blank_src = (idx_q == '0) ? bus.blank  : sh_blank_q;
    nib       = num_src[{idx_q, 2'b00} +: 4];
    seg       = hex_seg(nib);
    if (dp_src[idx_q])    seg[0] = 1'b1;
    if (blank_src[idx_q]) seg    = 8'h00;
    if (!SEG_ACTIVE_HIGH) seg    = ~seg;
    enc_byte  = LSB_FIRST ? seg : rev8(seg);
  end

  assign sel_on = (NUM_DIGITS'(1) << idx_q) ^ SEL_OFF;

  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    tmr_n      = tmr_q;
    bit_n      = bit_q;
    byte_n     = byte_q;
    sh_num_n   = sh_num_q;
    sh_dp_n    = sh_dp_q;
    sh_blank_n = sh_blank_q;
    ser_n      = ser_q;
    sclk_n     = sclk_q;
    rclk_n     = 1'b0;
    sel_n      = sel_q;
    fdone_n    = 1'b0;
    case (state_q)
      S_IDLE: state_n = S_LOAD;
      S_LOAD: begin
        if (idx_q == '0) begin
          sh_num_n   = bus.disnum;
          sh_dp_n    = bus.dp_en;
          sh_blank_n = bus.blank;
        end
        byte_n  = enc_byte;
        bit_n   = 3'd0;
        ser_n   = enc_byte[0];
        sclk_n  = 1'b0;
        tmr_n   = DIV_LD;
        state_n = S_SHIFT;
      end
      S_SHIFT: begin
        if (tmr_q != '0) begin
          tmr_n = tmr_q - TW'(1);
        end else if (!sclk_q) begin
          sclk_n = 1'b1;
          tmr_n  = DIV_LD;
        end else begin
          sclk_n = 1'b0;
          tmr_n  = DIV_LD;
          if (bit_q == 3'd7) begin
            state_n = S_LATCH;
            rclk_n  = 1'b1;
            sel_n   = sel_on;
            fdone_n = (idx_q == LAST_IDX);
          end else begin
            bit_n = bit_q + 3'd1;
            ser_n = byte_q[bit_q + 3'd1];
          end
        end
      end
      S_LATCH: begin
        tmr_n   = DWELL_LD;
        state_n = S_HOLD;
      end
      S_HOLD: begin
        if (tmr_q != '0) begin
          tmr_n = tmr_q - TW'(1);
        end else begin
          state_n = S_LOAD;
          idx_n   = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      tmr_q      <= '0;
      bit_q      <= '0;
      byte_q     <= '0;
      sh_num_q   <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      ser_q      <= 1'b0;
      sclk_q     <= 1'b0;
      rclk_q     <= 1'b0;
      sel_q      <= SEL_OFF;
      fdone_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      tmr_q      <= tmr_n;
      bit_q      <= bit_n;
      byte_q     <= byte_n;
      sh_num_q   <= sh_num_n;
      sh_dp_q    <= sh_dp_n;
      sh_blank_q <= sh_blank_n;
      ser_q      <= ser_n;
      sclk_q     <= sclk_n;
      rclk_q     <= rclk_n;
      sel_q      <= sel_n;
      fdone_q    <= fdone_n;
    end
  end

  assign bus.SER        = ser_q;
  assign bus.SCLK       = sclk_q;
  assign bus.RCLK       = rclk_q;
  assign bus.SEL        = sel_q;
  assign bus.frame_done = fdone_q;

endmodule
